// File: rtl/i2c_codec_cfg_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_codec_cfg_if
//  Description : Bus bundle between the codec configuration sequencer and the
//                downstream I2C master, plus the sequencer's control/status.
//
//  Signals
//    go        restart request into the sequencer
//    ready     I2C master idle / able to accept start
//    start     single-cycle write request to the I2C master
//    i2c_data  {device address, register[6:0], value[8:0]} transfer word
//    busy      sequence in progress
//    done      all table entries written
//    index     table entry currently being written
//
//  Modports
//    master    the sequencer side (it initiates the I2C writes)
//    slave     the I2C master / system side
//
//  Revision    : 1.0  initial release
// ============================================================================
interface i2c_codec_cfg_if;
    logic        go;
    logic        ready;
    logic        start;
    logic [23:0] i2c_data;
    logic        busy;
    logic        done;
    logic [3:0]  index;

    modport master (
        input  go,
        input  ready,
        output start,
        output i2c_data,
        output busy,
        output done,
        output index
    );

    modport slave (
        output go,
        output ready,
        input  start,
        input  i2c_data,
        input  busy,
        input  done,
        input  index
    );
endinterface
`default_nettype wire

// File: rtl/i2c_codec_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_codec_cfg
//  Description : WM8731 register-write sequencer. After reset (or a go
//                request from IDLE/DONE) it waits a power-up delay, then
//                walks a fixed 11-entry initialisation table, handshaking one
//                I2C write per entry with the downstream master via
//                start/ready. done flags a fully configured codec.
//
//  Ports
//    clk       system clock, all logic on the rising edge
//    reset     synchronous, active-high; returns to PWR_WAIT with all
//              outputs cleared
//    bus       i2c_codec_cfg_if.master:
//                go (in), ready (in), start, i2c_data[23:0], busy, done,
//                index[3:0] (out)
//
//  Parameters
//    DEV_ADDR    8-bit I2C write address placed in i2c_data[23:16]
//    INIT_DELAY  cycles waited before the first write (<= 65535)
//    GAP_CYCLES  idle cycles after each completed write (<= 65535)
//
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_codec_cfg #(
    parameter logic [7:0]  DEV_ADDR   = 8'h34,
    parameter int unsigned INIT_DELAY = 50000,
    parameter int unsigned GAP_CYCLES = 64
) (
    input  wire             clk,
    input  wire             reset,
    i2c_codec_cfg_if.master bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [15:0] c_INIT_DELAY = 16'(INIT_DELAY);
    localparam logic [15:0] c_GAP_CYCLES = 16'(GAP_CYCLES);
    // Eight cycles of ready staying high after start means the master never
    // saw the request; the counter runs 0..7 across those cycles.
    localparam logic [15:0] c_ACK_LAST   = 16'd7;
    localparam logic [3:0]  c_LAST_INDEX = 4'd10;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PWR_WAIT  = 3'd1,
        S_LOAD      = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_ACK  = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_GAP       = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [3:0]  r_index;
    logic [3:0]  w_index_nxt;
    logic [23:0] r_data;
    logic        r_start;
    logic        r_busy;
    logic        r_done;
    logic        w_load;
    logic [15:0] w_tbl_word;

    // ------------------------------------------------------------------------
    // WM8731 initialisation table: {reg[6:0], val[8:0]}
    //   0 R15 reset, 1/2 line-in L/R, 3/4 headphone L/R, 5 analogue path,
    //   6 digital path, 7 power-down, 8 interface format, 9 sampling,
    //   10 R9 active (must be last so the codec starts fully configured).
    // ------------------------------------------------------------------------
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        logic [15:0] word;
        unique case (idx)
            4'd0:    word = 16'h1E00;
            4'd1:    word = 16'h0017;
            4'd2:    word = 16'h0217;
            4'd3:    word = 16'h0479;
            4'd4:    word = 16'h0679;
            4'd5:    word = 16'h0812;
            4'd6:    word = 16'h0A00;
            4'd7:    word = 16'h0C00;
            4'd8:    word = 16'h0E01;
            4'd9:    word = 16'h1000;
            4'd10:   word = 16'h1201;
            default: word = 16'h0000;
        endcase
        return word;
    endfunction

    // ------------------------------------------------------------------------
    // Next-state logic. One shared 16-bit counter serves the power-up delay,
    // the inter-write gap and the acknowledge timeout; it returns to zero on
    // every state change so each phase starts counting from 0.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_index_nxt = r_index;

        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.go) begin
                    w_state_nxt = S_PWR_WAIT;
                    w_index_nxt = 4'd0;
                end
            end

            // Stays N+1 cycles: N counts plus the cycle that sees the
            // terminal value, so N=0 passes straight through in one cycle.
            S_PWR_WAIT: begin
                if (r_cnt == c_INIT_DELAY) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            // A reset may have left the master mid-transfer, so never issue
            // until it reports idle.
            S_LOAD: begin
                if (bus.ready) begin
                    w_state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_state_nxt = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                if (!bus.ready) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == c_ACK_LAST) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            S_WAIT_DONE: begin
                if (bus.ready) begin
                    w_state_nxt = S_GAP;
                end
            end

            S_GAP: begin
                if (r_cnt == c_GAP_CYCLES) begin
                    if (r_index == c_LAST_INDEX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_index_nxt = r_index + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The transfer word is captured only on entry to LOAD, using the index
    // that LOAD will present, so it is stable from the cycle before start
    // until the master has finished and the gap has elapsed.
    assign w_load     = (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
    assign w_tbl_word = table_word(w_index_nxt);

    // ------------------------------------------------------------------------
    // State and output registers. Outputs are registered from the next state
    // so they line up with the state they describe, and all read 0 while
    // reset is held even though the reset state is PWR_WAIT.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_PWR_WAIT;
            r_cnt   <= '0;
            r_index <= '0;
            r_data  <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_index <= w_index_nxt;
            if (w_load) begin
                r_data <= {DEV_ADDR, w_tbl_word};
            end
            // ISSUE always lasts one cycle and is only entered with ready
            // high, which keeps start a clean single-cycle pulse.
            r_start <= (w_state_nxt == S_ISSUE);
            r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign bus.start    = r_start;
    assign bus.i2c_data = r_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.index    = r_index;

endmodule
`default_nettype wire

// File: tb/tb_i2c_codec_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_codec_cfg
//  Description : Self-checking bench for i2c_codec_cfg. Stimulus pushes the
//                expected {i2c_data, index} of every start pulse into a queue;
//                a monitor pops and compares on each observed start. Directed
//                checks cover reset values, timing and completion status.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_codec_cfg;

    localparam int unsigned INIT_DELAY = 16;
    localparam int unsigned GAP_CYCLES = 4;

    typedef struct packed {
        logic [23:0] data;
        logic [3:0]  idx;
    } exp_t;

    logic clk;
    logic reset;
    logic model_ready;
    logic hold_low;
    logic respond;

    i2c_codec_cfg_if bus ();

    i2c_codec_cfg #(
        .DEV_ADDR   (8'h34),
        .INIT_DELAY (INIT_DELAY),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.ready = model_ready & ~hold_low;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written WM8731 words
    logic [15:0] tbl [11];
    initial begin
        tbl[0]  = 16'h1E00; tbl[1]  = 16'h0017; tbl[2]  = 16'h0217;
        tbl[3]  = 16'h0479; tbl[4]  = 16'h0679; tbl[5]  = 16'h0812;
        tbl[6]  = 16'h0A00; tbl[7]  = 16'h0C00; tbl[8]  = 16'h0E01;
        tbl[9]  = 16'h1000; tbl[10] = 16'h1201;
    end

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Cycle numbering: the first edge with reset low is cycle 0; a value
    // sampled at a negedge is the value for the next cycle number.
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_entry(input int i);
        exp_t e;
        e.data = {8'h34, tbl[i]};
        e.idx  = 4'(i);
        exp_q.push_back(e);
    endtask

    task automatic push_range(input int first, input int last);
        for (int i = first; i <= last; i++) push_entry(i);
    endtask

    // ---------------------------------------------------------------- monitor
    int   start_count        = 0;
    int   starts_since_reset = 0;
    int   first_start_cyc    = -1;
    int   last_start_cyc     = 0;
    int   prev_start_cyc     = 0;
    logic prev_start         = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            starts_since_reset = 0;
            prev_start         = 1'b0;
        end else begin
            if (bus.start === 1'b1) begin
                chk("start_back_to_back", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_start: got data %0h index %0d, expected no start", bus.i2c_data, bus.index);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_i2c_data", 32'(bus.i2c_data), 32'(e.data));
                    chk("sb_index", 32'(bus.index), 32'(e.idx));
                end
                if (starts_since_reset == 0) first_start_cyc = cyc;
                prev_start_cyc = last_start_cyc;
                last_start_cyc = cyc;
                start_count++;
                starts_since_reset++;
            end
            prev_start = bus.start;
        end
    end

    // ---------------------------------------------------------- master model
    initial begin
        model_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && bus.start === 1'b1 && respond) begin
                repeat (2) @(negedge clk);
                model_ready = 1'b0;
                repeat (20) @(negedge clk);
                model_ready = 1'b1;
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_start"},    32'(bus.start),    32'd0);
        chk({tag, "_i2c_data"}, 32'(bus.i2c_data), 32'd0);
        chk({tag, "_busy"},     32'(bus.busy),     32'd0);
        chk({tag, "_done"},     32'(bus.done),     32'd0);
        chk({tag, "_index"},    32'(bus.index),    32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"},        32'(bus.done),     32'd1);
        chk({tag, "_busy"},        32'(bus.busy),     32'd0);
        chk({tag, "_index"},       32'(bus.index),    32'd10);
        chk({tag, "_last_data"},   32'(bus.i2c_data), 32'h0034_1201);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_starts(input int target, input int limit);
        int n;
        n = 0;
        while (start_count < target && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        int base;
        int rel;
        int n;

        reset    = 1'b1;
        bus.go   = 1'b0;
        hold_low = 1'b0;
        respond  = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");

        // Run 1: auto-start after reset, full table, go while busy ignored
        push_range(0, 10);
        reset = 1'b0;
        @(negedge clk);
        chk("run1_busy_cycle1", 32'(bus.busy), 32'd1);
        while (cyc < 40) @(negedge clk);
        chk("run1_busy_before_go", 32'(bus.busy), 32'd1);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        wait_done("run1");
        chk("run1_first_start_cycle", 32'(first_start_cyc), 32'd18);
        repeat (3) @(negedge clk);
        chk("run1_done_held", 32'(bus.done), 32'd1);

        // Run 2: go from DONE, master ignores start first, then reset mid-run
        respond = 1'b0;
        repeat (4) push_entry(0);
        push_range(1, 5);
        base = start_count;
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        chk("go_done_cleared", 32'(bus.done),  32'd0);
        chk("go_busy_set",     32'(bus.busy),  32'd1);
        chk("go_index_zero",   32'(bus.index), 32'd0);
        wait_starts(base + 2, 200);
        chk("retry_spacing_1", 32'(last_start_cyc - prev_start_cyc), 32'd9);
        wait_starts(base + 3, 50);
        chk("retry_spacing_2", 32'(last_start_cyc - prev_start_cyc), 32'd9);
        @(negedge clk);
        respond = 1'b1;
        wait_starts(base + 9, 1500);
        chk("run2_reached_index5", 32'(start_count), 32'(base + 9));
        repeat (5) @(negedge clk);
        reset    = 1'b1;
        hold_low = 1'b1;
        @(negedge clk);
        chk_zero_outputs("abort");
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);

        // Run 3: restart after abort, ready held low at LOAD entry
        repeat (2) @(negedge clk);
        push_range(0, 10);
        reset = 1'b0;
        @(negedge clk);
        chk("run3_busy_cycle1", 32'(bus.busy), 32'd1);
        while (cyc < 17) @(negedge clk);
        chk("run3_load_data",  32'(bus.i2c_data), 32'h0034_1E00);
        chk("run3_load_index", 32'(bus.index),    32'd0);
        chk("run3_load_no_start", 32'(bus.start), 32'd0);
        repeat (30) @(negedge clk);
        chk("run3_no_start_while_low", 32'(starts_since_reset), 32'd0);
        rel = cyc;
        hold_low = 1'b0;
        n = 0;
        while (starts_since_reset < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("run3_start_after_ready", 32'(first_start_cyc), 32'(rel + 1));
        wait_done("run3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected test completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/i2c_codec_cfg.md
# i2c_codec_cfg

Register-write sequencer that sits directly upstream of the I2C master in the audio path. After reset (or on request) it waits a power-up delay, then walks a fixed 11-entry WM8731 initialisation table. For each entry it presents a 24-bit transfer word to the master and handshakes one write per entry via start/ready. It flags completion when the codec is configured.

## Interface
- DEV_ADDR, 8'h34, 8-bit I2C write address (7-bit 0x1A plus R/W=0), placed in i2c_data[23:16]
- INIT_DELAY, 50000, cycles waited after reset or go before the first write (1 ms at 50 MHz)
- GAP_CYCLES, 64, idle cycles inserted after each completed write before the next is loaded
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; overrides all other inputs
- go  input  1  restart the whole sequence; sampled only in IDLE or DONE
- ready  input  1  from I2C master; 1 = idle and able to accept start
- start  output  1  to I2C master; single-cycle request pulse
- i2c_data  output  24  {DEV_ADDR, reg[6:0], val[8:0]}; stable from 1 cycle before start until ready returns high
- busy  output  1  1 while the sequence is in progress
- done  output  1  1 after all 11 writes complete; held until go or reset
- index  output  4  table entry currently being written (0..10)

## Operation
- Fixed table, indices 0..10, 16-bit words: 1E00 (R15 reset), 0017, 0217, 0479, 0679, 0812, 0A00, 0C00, 0E01, 1000, 1201 (R9 active, last).
- States: IDLE, PWR_WAIT, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, GAP, DONE.
- Reset: state PWR_WAIT, delay counter 0, index 0. All outputs 0: start, i2c_data, busy, done, index.
- The sequence auto-starts on reset release. go is only needed for a re-run.
- PWR_WAIT: busy=1, counts INIT_DELAY cycles, then goes to LOAD.
- LOAD: drives i2c_data = {DEV_ADDR, table[index]}. Goes to ISSUE when ready=1; otherwise stays in LOAD.
- ISSUE: start=1 for exactly one cycle, then WAIT_ACK.
- WAIT_ACK: waits for ready=0. If ready stays 1 for 8 cycles, returns to ISSUE and re-pulses start. Retries are unlimited.
- WAIT_DONE: waits for ready=1, then enters GAP.
- GAP: counts GAP_CYCLES. Then, if index==10, goes to DONE; otherwise index+1 and LOAD.
- DONE: busy=0, done=1, i2c_data holds its last value.
- go=1 in DONE or IDLE: clears done, sets index=0 and busy=1, enters PWR_WAIT.
- go while busy is ignored.
- Delay and gap counters are 16 bits wide. INIT_DELAY and GAP_CYCLES must be ≤ 65535; a value of 0 means pass through in 1 cycle.
- Reset mid-transfer aborts immediately to the reset state. The master is not signalled; it finishes its own transfer, and LOAD waits for ready=1 before the next start.

## Timing
- Reset release (first edge with reset=0) is cycle 0: busy=1 from cycle 1.
- With INIT_DELAY=N, LOAD is entered at cycle N+1 and start pulses at N+2, provided ready=1.
- i2c_data changes only on LOAD entry: at least 1 cycle of setup before start, held through WAIT_DONE.
- start never asserts while ready=0, and never on two consecutive cycles.
- Per-entry overhead beyond the master's transfer time: 1 (LOAD) + 1 (ISSUE) + GAP_CYCLES + 1 cycles.
- done rises 1 cycle after the final GAP count expires; busy falls on the same edge.

## Test plan
- Reset release with INIT_DELAY=16, GAP_CYCLES=4, ready tied 1 by model -> start first pulses at cycle 18, i2c_data=24'h341E00, index=0.
- Master model drops ready 2 cycles after start and raises it 20 cycles later -> 11 start pulses; i2c_data sequence 341E00, 340017, …, 341201; then done=1, busy=0, index=10.
- Model ignores start (ready stays 1) -> start re-pulses every 9 cycles with i2c_data unchanged; model then responds -> sequence resumes at the same index.
- ready held 0 at LOAD entry for 30 cycles -> no start until ready=1, then start 1 cycle later.
- Assert reset during WAIT_DONE of index 5 -> next edge: all outputs 0; sequence restarts at index 0 after INIT_DELAY.
- go pulse while busy -> ignored. go pulse in DONE -> done=0 and busy=1 next cycle; full 11-write sequence repeats.
